// File: rtl/fb_scanout_if.sv
// Frame-buffer port-B read bus: fb_addr (to memory), fb_q (from memory).
// master = scanout side (drives fb_addr), slave = frame buffer side.
interface fb_scanout_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_q;

  modport master (output fb_addr, input fb_q);
  modport slave  (input fb_addr, output fb_q);
endinterface

// File: rtl/fb_scanout.sv
// VGA scanout: raster counters, linear fb read address, aligned pixel/sync/de.
// Ports: clock, reset, fb (fb_scanout_if.master), pixel, hsync_n, vsync_n,
// de, frame_start; test_en only with `define FB_SCANOUT_TESTPAT_EN.
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 19
) (
  input  logic       clock,
  input  logic       reset,
  fb_scanout_if.master fb,
`ifdef FB_SCANOUT_TESTPAT_EN
  input  logic       test_en,
`endif
  output logic [7:0] pixel,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L       = RD_LATENCY;

  logic [10:0]       h_cnt, v_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic h_end, v_end, act, last_px;
  logic hs_raw, vs_raw, fs_raw;

  logic [L-1:0] de_p, hs_p, vs_p, fs_p;
  logic [7:0]   src;

  assign h_end   = h_cnt == 11'(H_TOTAL - 1);
  assign v_end   = v_cnt == 11'(V_TOTAL - 1);
  assign act     = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
  assign last_px = (h_cnt == 11'(H_ACTIVE - 1)) &&
                   (v_cnt == 11'(V_ACTIVE - 1));
  assign hs_raw  = (h_cnt >= 11'(H_ACTIVE + H_FP)) &&
                   (h_cnt <  11'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw  = (v_cnt >= 11'(V_ACTIVE + V_FP)) &&
                   (v_cnt <  11'(V_ACTIVE + V_FP + V_SYNC));
  assign fs_raw  = (h_cnt == 11'd0) && (v_cnt == 11'd0);

  assign fb.fb_addr = addr_q;

  // Address tracks the counters incrementally; it parks on the last
  // pixel address through vertical blanking and clears at frame wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      addr_q <= '0;
    end else begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
      if (h_end && v_end)
        addr_q <= '0;
      else if (act && !last_px)
        addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Control delayed to line up with the memory's registered q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de_p <= '0;
      hs_p <= '0;
      vs_p <= '0;
      fs_p <= '0;
    end else begin
      de_p[0] <= act;
      hs_p[0] <= hs_raw;
      vs_p[0] <= vs_raw;
      fs_p[0] <= fs_raw;
      for (int i = 1; i < L; i++) begin
        de_p[i] <= de_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        fs_p[i] <= fs_p[i-1];
      end
    end
  end

`ifdef FB_SCANOUT_TESTPAT_EN
  logic [7:0] pat_p [L];
  logic [L-1:0] te_p;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      te_p <= '0;
      for (int i = 0; i < L; i++)
        pat_p[i] <= '0;
    end else begin
      te_p[0]  <= test_en;
      pat_p[0] <= h_cnt[7:0] ^ v_cnt[7:0];
      for (int i = 1; i < L; i++) begin
        te_p[i]  <= te_p[i-1];
        pat_p[i] <= pat_p[i-1];
      end
    end
  end

  assign src = te_p[L-1] ? pat_p[L-1] : fb.fb_q;
`else
  assign src = fb.fb_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel       <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel       <= de_p[L-1] ? src : 8'd0;
      hsync_n     <= ~hs_p[L-1];
      vsync_n     <= ~vs_p[L-1];
      de          <= de_p[L-1];
      frame_start <= fs_p[L-1] & de_p[L-1];
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced raster.
// Expected outputs queued per counter state, compared 3 cycles later.
module tb_fb_scanout;

  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] BLANK = {8'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic te = 1'b0;
  logic [7:0] pixel;
  logic hsync_n, vsync_n, de, frame_start;
  logic [18:0] a_r;

  int checks = 0;
  int failures = 0;
  int mh = 0, mv = 0, k = 0;
  int de_cnt = 0, fs_cnt = 0;
  logic [11:0] q[$];

  fb_scanout_if #(.ADDR_W(19)) fbi ();

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LATENCY(2), .ADDR_W(19)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fb(fbi.master),
`ifdef FB_SCANOUT_TESTPAT_EN
    .test_en(te),
`endif
    .pixel(pixel),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n),
    .de(de),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Frame buffer: registered address, registered q = addr[7:0].
  always @(posedge clock) begin
    a_r <= fbi.fb_addr;
    fbi.fb_q <= a_r[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d k=%0d)",
               tag, got, exp, mh, mv, k);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (h < HA && v < VA) return v * HA + h;
    if (v < VA) return ((v + 1) * HA < HA * VA) ? (v + 1) * HA : HA * VA - 1;
    return HA * VA - 1;
  endfunction

  function automatic logic [11:0] exp_out(input int h, input int v,
                                          input logic t);
    logic a, hs, vs, fs;
    logic [7:0] p;
    int ad, pt;
    a  = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HS);
    vs = (v >= VA + VF) && (v < VA + VF + VS);
    fs = (h == 0) && (v == 0);
    ad = v * HA + h;
    pt = h ^ v;
    p  = !a ? 8'd0 : (t ? pt[7:0] : ad[7:0]);
    return {p, ~hs, ~vs, a, fs};
  endfunction

  task automatic step(input bit win);
    logic [11:0] got;
    got = {pixel, hsync_n, vsync_n, de, frame_start};
    chk("fb_addr", 32'(fbi.fb_addr), 32'(exp_addr(mh, mv)));
    q.push_back(exp_out(mh, mv, te));
    if (q.size() > 3) chk("out", 32'(got), 32'(q.pop_front()));
    else chk("blank", 32'(got), 32'(BLANK));
    if (win && k >= 3 && k < 3 + FRAME) begin
      de_cnt += int'(de);
      fs_cnt += int'(frame_start);
    end
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    k++;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_out", 32'({pixel, hsync_n, vsync_n, de, frame_start}),
        32'(BLANK));
    chk("rst_addr", 32'(fbi.fb_addr), 32'd0);
    reset = 1'b0;

    repeat (FRAME + 10) step(1'b1);
    chk("de_per_frame", de_cnt, HA * VA);
    chk("fs_per_frame", fs_cnt, 1);

    for (int i = 0; i < FRAME; i++) begin
      if (mh == 30 && mv == 5) break;
      step(1'b0);
    end
    chk("reach_mid", 32'(mh * 100 + mv), 32'(3005));

    reset = 1'b1;
    #1;
    chk("midrst_out", 32'({pixel, hsync_n, vsync_n, de, frame_start}),
        32'(BLANK));
    chk("midrst_addr", 32'(fbi.fb_addr), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    mh = 0;
    mv = 0;
    k = 0;

    for (int i = 0; i < FRAME + 10; i++) begin
`ifdef FB_SCANOUT_TESTPAT_EN
      if (k == 2 * HT + 7) te = 1'b1;
`endif
      step(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Display-side read stage directly downstream of the 640x480x8 frame buffer (five 64K banks behind a 19-bit linear address).
- Generates VGA raster timing and drives the frame buffer's port-B read address, one linear address per active pixel.
- Consumes the frame buffer's registered read data and outputs pixel data, syncs and display-enable, all aligned to one pipeline.
- Runs on the pixel clock; the frame buffer's port-B address and output registers share this clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- RD_LATENCY, 2, frame-buffer read latency in cycles (registered address plus registered q)
- ADDR_W, 19, frame-buffer address width

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- fb_addr  out  ADDR_W  read address to frame buffer port B
- fb_q  in  8  read data from frame buffer port B
- pixel  out  8  RGB332 pixel; 0 when blanked
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  display enable (active-area pixel)
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525; v_cnt increments when h_cnt wraps.
  - Both wrap to 0 at (H_TOTAL-1, V_TOTAL-1). Frame period = 420000 cycles.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- fb_addr is a register:
  - While the counters sit on active (h,v), fb_addr = v*H_ACTIVE + h.
  - It increments by 1 after each active cycle and holds during blanking.
  - It returns to 0 on the cycle the counters wrap to (0,0).
  - No multiplier. Maximum value is 307199; it never reaches 307200 or higher.
- Raw timing from counter state:
  - hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - First pixel is (0,0) active.
- Pipeline:
  - Raw de, hsync, vsync and first-pixel flag are delayed through RD_LATENCY shift stages.
  - fb_q is then sampled against the delayed de.
  - All outputs are registered; outputs reflect counter state RD_LATENCY+1 cycles earlier (3 by default).
  - pixel = delayed_de ? fb_q : 8'd0.
- Reset values: counters 0; fb_addr 0; pixel 0; hsync_n 1; vsync_n 1; de 0; frame_start 0; all pipeline stages cleared (inactive).
- Reset mid-frame: all outputs go to their reset values immediately (asynchronous). After release, the raster restarts at (0,0) with fb_addr 0. The partial frame is discarded and no stale pixel is emitted.
- First frame after reset: the first RD_LATENCY+1 cycles output blank. frame_start first pulses at cycle RD_LATENCY+1 after release.
- Write-port activity on the frame buffer (port A) is independent of this block; no handshake.

Optional Feature:
- Macro: FB_SCANOUT_TESTPAT_EN.
- When defined:
  - Adds input port test_en (1 bit).
  - When test_en=1, the active pixel is (h_cnt[7:0] ^ v_cnt[7:0]) taken from the delayed counter values, with the same latency and blanking as normal data; fb_q is ignored.
  - fb_addr keeps advancing normally.
  - test_en is sampled per pixel at counter stage, so a mid-frame change takes effect on the next pixel.
- When not defined: no test_en port; pixel is always taken from fb_q.

Test Plan:
- Address sequence: fb_addr = 0 at (0,0); 639 at (639,0); 640 at (0,1); 307199 at (639,479); 0 again at next (0,0); fb_addr constant across every blanking interval.
- Timing: hsync_n low exactly 96 cycles per 800-cycle line, falling at output cycle 656+3 of line; vsync_n low for exactly 2 lines (490–491); de high for 640x480 = 307200 cycles per 420000-cycle frame.
- Data alignment, with a 2-cycle-latency frame-buffer model returning addr[7:0]:
  - Output pixel at raster (h,v) = (v*640+h) & 8'hFF whenever de=1, e.g. (5,1) -> 8'h85.
  - pixel = 0 whenever de=0.
- Reset mid-frame: assert reset at (300,200):
  - Same cycle: pixel=0, de=0, hsync_n=1, vsync_n=1.
  - After release: fb_addr=0, frame_start pulses at cycle 3, and the first output pixel equals model data for address 0.
- frame_start: exactly one pulse per 420000 cycles, coincident with the first de=1 cycle of the frame.
- With FB_SCANOUT_TESTPAT_EN and test_en=1: output pixel at (5,3) = 8'h06, at (255,255) = 8'h00; blanking unchanged.
